line_sum_generator: RTL and testbench

- Producer side of the line-sum interface: consumes a raster stream of pixel pairs (reference frame vs. test frame) and computes the per-pixel squared difference.
- Sums the squared differences over each line of LINE_SIZE pixels and emits one registered line_sum per line with a one-cycle line_valid strobe.
- Feeds the line-sum accumulator stage of the MSE/PSNR path; also tracks lines per frame and flags frame completion and resync errors.

---
 rtl/frame_metrics_pkg.sv | 29 ++
 rtl/line_sum_generator_sq_diff_pipe.sv | 91 +++++++++
 rtl/line_sum_generator.sv | 190 +++++++++++++++++++
 tb/tb_line_sum_generator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_metrics_pkg.sv
// Shared constants, width helpers and the FSM state type for the frame
// metrics (MSE/PSNR) path. The line-sum generator and the downstream
// line-sum accumulator both size their datapaths from these helpers.
package frame_metrics_pkg;

  localparam int PIXEL_SIZE_DEF   = 8;
  localparam int LINE_SIZE_DEF    = 640;
  localparam int NUM_OF_LINES_DEF = 480;

  // Width of a per-line sum of squared differences: LINE_SIZE * (2^P-1)^2 fits.
  function automatic int calc_line_sum_w(input int line_size, input int pixel_size);
    return $clog2(line_size) + 2 * pixel_size;
  endfunction

  // Counter/index width, never narrower than one bit.
  function automatic int calc_idx_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int LINE_SUM_W = calc_line_sum_w(LINE_SIZE_DEF, PIXEL_SIZE_DEF);
  localparam int LINE_IDX_W = calc_idx_w(NUM_OF_LINES_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/line_sum_generator_sq_diff_pipe.sv
// sq_diff_pipe: two-stage |a-b| then square pipeline carrying a valid bit,
// a last-of-line tag and a generic sideband tag alongside the data.
// Ports:
//   CLK, reset     clock, asynchronous active-high reset
//   i_flush        synchronous invalidate of all in-flight entries
//   i_valid        input pixel pair valid
//   i_pixel_a/b    reference / test pixel
//   i_last         pixel is the last of its line
//   i_tag          sideband travelling with the pixel
//   o_valid/o_sq   squared difference out (stage 2)
//   o_last/o_tag   sideband out, aligned with o_sq
//   o_busy         any stage holds a valid entry
module sq_diff_pipe #(
  parameter int PIXEL_SIZE = 8,
  parameter int TAG_W      = 1
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    i_flush,
  input  logic                    i_valid,
  input  logic [PIXEL_SIZE-1:0]   i_pixel_a,
  input  logic [PIXEL_SIZE-1:0]   i_pixel_b,
  input  logic                    i_last,
  input  logic [TAG_W-1:0]        i_tag,
  output logic                    o_valid,
  output logic [2*PIXEL_SIZE-1:0] o_sq,
  output logic                    o_last,
  output logic [TAG_W-1:0]        o_tag,
  output logic                    o_busy
);

  logic                    r_s1_valid;
  logic [PIXEL_SIZE-1:0]   r_s1_diff;
  logic                    r_s1_last;
  logic [TAG_W-1:0]        r_s1_tag;
  logic                    r_s2_valid;
  logic [2*PIXEL_SIZE-1:0] r_s2_sq;
  logic                    r_s2_last;
  logic [TAG_W-1:0]        r_s2_tag;

  logic [PIXEL_SIZE-1:0]   w_diff;
  logic [2*PIXEL_SIZE-1:0] w_diff_ext;

  // Unsigned absolute difference cannot overflow PIXEL_SIZE bits.
  assign w_diff     = (i_pixel_a >= i_pixel_b) ? (i_pixel_a - i_pixel_b)
                                               : (i_pixel_b - i_pixel_a);
  assign w_diff_ext = {{PIXEL_SIZE{1'b0}}, r_s1_diff};

  // Stage 1: absolute difference plus sideband.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_diff  <= '0;
      r_s1_last  <= 1'b0;
      r_s1_tag   <= '0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_diff  <= w_diff;
      r_s1_last  <= i_valid & i_last;
      r_s1_tag   <= i_tag;
    end
  end

  // Stage 2: square of the difference.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_sq    <= '0;
      r_s2_last  <= 1'b0;
      r_s2_tag   <= '0;
    end else if (i_flush) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_sq    <= w_diff_ext * w_diff_ext;
      r_s2_last  <= r_s1_valid & r_s1_last;
      r_s2_tag   <= r_s1_tag;
    end
  end

  assign o_valid = r_s2_valid;
  assign o_sq    = r_s2_sq;
  assign o_last  = r_s2_last;
  assign o_tag   = r_s2_tag;
  assign o_busy  = r_s1_valid | r_s2_valid;

endmodule

// File: rtl/line_sum_generator.sv
// line_sum_generator: consumes a raster stream of reference/test pixel pairs,
// sums squared differences per line and reports one line_sum per line.
// Ports:
//   CLK, reset          clock, asynchronous active-high reset
//   frame_start         arms / restarts frame capture
//   pixel_valid         pixel_a/pixel_b valid this cycle
//   pixel_a, pixel_b    reference and test pixel
//   line_sum/line_idx   result of the last completed line (held)
//   line_valid          one-cycle strobe, new line_sum
//   frame_done          strobe with line_valid of the frame's last line
//   sync_err            strobe, frame_start arrived mid-frame
//   busy                capturing, or results still in flight
module line_sum_generator
  import frame_metrics_pkg::*;
#(
  parameter  int PIXEL_SIZE   = PIXEL_SIZE_DEF,
  parameter  int LINE_SIZE    = LINE_SIZE_DEF,
  parameter  int NUM_OF_LINES = NUM_OF_LINES_DEF,
  localparam int LSW          = calc_line_sum_w(LINE_SIZE, PIXEL_SIZE),
  localparam int IDXW         = calc_idx_w(NUM_OF_LINES)
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  pixel_valid,
  input  logic [PIXEL_SIZE-1:0] pixel_a,
  input  logic [PIXEL_SIZE-1:0] pixel_b,
  output logic [LSW-1:0]        line_sum,
  output logic                  line_valid,
  output logic [IDXW-1:0]       line_idx,
  output logic                  frame_done,
  output logic                  sync_err,
  output logic                  busy
);

  localparam int PIXW  = calc_idx_w(LINE_SIZE);
  localparam int TAG_W = IDXW + 1;
  localparam int SQW   = 2 * PIXEL_SIZE;

  state_t              r_state;
  logic [PIXW-1:0]     r_pix_cnt;
  logic [IDXW-1:0]     r_line_cnt;
  logic                r_sync_err;
  logic [LSW-1:0]      r_acc;
  logic                r_s3_valid;
  logic                r_s3_last;
  logic [TAG_W-1:0]    r_s3_tag;
  logic [LSW-1:0]      r_line_sum;
  logic                r_line_valid;
  logic [IDXW-1:0]     r_line_idx;
  logic                r_frame_done;

  logic                w_active;
  logic                w_last_pix;
  logic                w_final_pix;
  logic                w_resync;
  logic                w_accept;
  logic                w_pipe_valid;
  logic [SQW-1:0]      w_pipe_sq;
  logic                w_pipe_last;
  logic [TAG_W-1:0]    w_pipe_tag;
  logic                w_pipe_busy;
  logic                w_drain_done;
  logic [LSW-1:0]      w_acc_base;
  logic [LSW-1:0]      w_sq_ext;

  assign w_active    = (r_state == ACTIVE);
  assign w_last_pix  = (r_pix_cnt == PIXW'(LINE_SIZE - 1));
  assign w_final_pix = w_active & pixel_valid & w_last_pix
                     & (r_line_cnt == IDXW'(NUM_OF_LINES - 1));
  // A frame_start that coincides with the frame's final pixel is a clean
  // back-to-back start, not a resync.
  assign w_resync    = w_active & frame_start & ~w_final_pix;
  assign w_accept    = w_active & pixel_valid & ~w_resync;
  assign w_drain_done = r_s3_last & r_s3_tag[IDXW];

  sq_diff_pipe #(
    .PIXEL_SIZE (PIXEL_SIZE),
    .TAG_W      (TAG_W)
  ) u_sq_diff_pipe (
    .CLK       (CLK),
    .reset     (reset),
    .i_flush   (w_resync),
    .i_valid   (w_accept),
    .i_pixel_a (pixel_a),
    .i_pixel_b (pixel_b),
    .i_last    (w_last_pix),
    .i_tag     ({w_final_pix, r_line_cnt}),
    .o_valid   (w_pipe_valid),
    .o_sq      (w_pipe_sq),
    .o_last    (w_pipe_last),
    .o_tag     (w_pipe_tag),
    .o_busy    (w_pipe_busy)
  );

  // The cycle after a tagged S3 starts the next line from zero.
  assign w_acc_base = r_s3_last ? '0 : r_acc;
  assign w_sq_ext   = w_pipe_valid ? {{(LSW - SQW){1'b0}}, w_pipe_sq} : '0;

  // Frame FSM with pixel/line counters and the resync strobe.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= w_resync;
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_state    <= ACTIVE;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (w_resync) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
          end else if (w_accept) begin
            if (w_last_pix) begin
              r_pix_cnt <= '0;
              if (w_final_pix) begin
                r_line_cnt <= '0;
                r_state    <= frame_start ? ACTIVE : DRAIN;
              end else begin
                r_line_cnt <= r_line_cnt + IDXW'(1);
              end
            end else begin
              r_pix_cnt <= r_pix_cnt + PIXW'(1);
            end
          end
        end
        DRAIN: begin
          if (frame_start) begin
            r_state    <= ACTIVE;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
          end else if (w_drain_done) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // S3 accumulation and registered line result.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_acc        <= '0;
      r_s3_valid   <= 1'b0;
      r_s3_last    <= 1'b0;
      r_s3_tag     <= '0;
      r_line_sum   <= '0;
      r_line_valid <= 1'b0;
      r_line_idx   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_line_valid <= r_s3_last & ~w_resync;
      r_frame_done <= w_drain_done & ~w_resync;
      if (r_s3_last && !w_resync) begin
        r_line_sum <= r_acc;
        r_line_idx <= r_s3_tag[IDXW-1:0];
      end
      if (w_resync) begin
        r_acc      <= '0;
        r_s3_valid <= 1'b0;
        r_s3_last  <= 1'b0;
        r_s3_tag   <= '0;
      end else begin
        r_acc      <= w_acc_base + w_sq_ext;
        r_s3_valid <= w_pipe_valid;
        r_s3_last  <= w_pipe_valid & w_pipe_last;
        r_s3_tag   <= w_pipe_tag;
      end
    end
  end

  assign line_sum   = r_line_sum;
  assign line_valid = r_line_valid;
  assign line_idx   = r_line_idx;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign busy       = (r_state != IDLE) | w_pipe_busy | r_s3_valid;

endmodule

// File: tb/tb_line_sum_generator.sv
module tb_line_sum_generator;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [7:0]  pixel_a = 8'd0;
  logic [7:0]  pixel_b = 8'd0;
  logic [17:0] line_sum;
  logic        line_valid;
  logic [0:0]  line_idx;
  logic        frame_done;
  logic        sync_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int sync_pulses = 0;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] idx;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  line_sum_generator #(
    .PIXEL_SIZE   (8),
    .LINE_SIZE    (4),
    .NUM_OF_LINES (2)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .pixel_a     (pixel_a),
    .pixel_b     (pixel_b),
    .line_sum    (line_sum),
    .line_valid  (line_valid),
    .line_idx    (line_idx),
    .frame_done  (frame_done),
    .sync_err    (sync_err),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  // Monitor: pops the scoreboard whenever a line result is presented.
  always @(negedge CLK) begin
    exp_t e;
    if (line_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_line_valid got sum=%0d idx=%0d fd=%0d required none",
                 line_sum, line_idx, frame_done);
      end else begin
        e = exp_q.pop_front();
        if (line_sum !== e.sum[17:0] || line_idx !== e.idx[0:0] ||
            frame_done !== e.fd || cyc_cnt != e.cyc) begin
          errors++;
          $display("FAIL line_result got sum=%0d idx=%0d fd=%0d cyc=%0d required sum=%0d idx=%0d fd=%0d cyc=%0d",
                   line_sum, line_idx, frame_done, cyc_cnt, e.sum, e.idx, e.fd, e.cyc);
        end
      end
    end else if (frame_done) begin
      checks++;
      errors++;
      $display("FAIL stray_frame_done got 1 required 0 without line_valid");
    end
    if (sync_err) sync_pulses++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic cyc(input logic fs, input logic v, input logic [7:0] a, input logic [7:0] b);
    frame_start = fs;
    pixel_valid = v;
    pixel_a     = a;
    pixel_b     = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic px(input logic [7:0] a, input logic [7:0] b);
    cyc(1'b0, 1'b1, a, b);
  endtask

  task automatic idle(input int n);
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called right after the edge that sampled a line's last pixel.
  task automatic expect_line(input int sum, input int idx, input logic fd);
    exp_t e;
    e.sum = sum;
    e.idx = idx;
    e.fd  = fd;
    e.cyc = cyc_cnt + 3;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input string name);
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got %0d pending required 0", name, exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  task automatic apply_reset();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    idle(1);
  endtask

  initial begin
    #2;
    check("rst_line_sum", line_sum, 0);
    check("rst_line_valid", line_valid, 0);
    check("rst_line_idx", line_idx, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_busy", busy, 0);
    apply_reset();

    // Single line, diffs 3,0,255,1.
    cyc(1'b1, 1'b0, 8'd0, 8'd0);
    check("busy_active", busy, 1);
    px(8'd10, 8'd7); px(8'd5, 8'd5); px(8'd255, 8'd0); px(8'd0, 8'd1);
    expect_line(65035, 0, 1'b0);
    wait_empty("single_line");
    apply_reset();

    // Full frame back-to-back.
    cyc(1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) px(8'd1, 8'd0);
    expect_line(4, 0, 1'b0);
    for (int i = 0; i < 4; i++) px(8'd0, 8'd2);
    expect_line(16, 1, 1'b1);
    wait_empty("full_frame");
    idle(3);
    check("busy_after_frame", busy, 0);

    // Pixels in IDLE are ignored.
    for (int i = 0; i < 4; i++) px(8'd9, 8'd0);
    idle(6);
    check("busy_idle_pixels", busy, 0);

    // Gapped frame.
    cyc(1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      px(8'd3, 8'd4);
    end
    expect_line(4, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      px(8'd2, 8'd0);
    end
    expect_line(16, 1, 1'b1);
    wait_empty("gapped_frame");
    idle(3);
    check("busy_after_gapped", busy, 0);

    // Mid-line resync; pixel with frame_start is dropped.
    cyc(1'b1, 1'b0, 8'd0, 8'd0);
    px(8'd5, 8'd0); px(8'd5, 8'd0);
    cyc(1'b1, 1'b1, 8'd9, 8'd0);
    check("sync_err_pulse", sync_err, 1);
    px(8'd1, 8'd0);
    check("sync_err_single", sync_err, 0);
    for (int i = 0; i < 3; i++) px(8'd1, 8'd0);
    expect_line(4, 0, 1'b0);
    wait_empty("resync");

    // Reset mid-line, outputs clear asynchronously.
    apply_reset();
    cyc(1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) px(8'd7, 8'd0);
    check("pre_reset_line_sum", line_sum, 0);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_line_sum", line_sum, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_line_valid", line_valid, 0);
    @(negedge CLK);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 8'd0, 8'd0);
    px(8'd0, 8'd0); px(8'd0, 8'd0); px(8'd0, 8'd0); px(8'd2, 8'd0);
    expect_line(4, 0, 1'b0);
    wait_empty("after_reset");
    check("held_line_sum", line_sum, 4);

    // Maximum-value line completes the frame.
    for (int i = 0; i < 4; i++) px(8'd255, 8'd0);
    expect_line(260100, 1, 1'b1);
    wait_empty("max_value");
    check("held_max_sum", line_sum, 260100);
    check("busy_after_max", busy, 0);

    // frame_start together with the final pixel of a frame.
    cyc(1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) px(8'd1, 8'd0);
    expect_line(4, 0, 1'b0);
    for (int i = 0; i < 3; i++) px(8'd3, 8'd0);
    cyc(1'b1, 1'b1, 8'd0, 8'd3);
    expect_line(36, 1, 1'b1);
    for (int i = 0; i < 4; i++) px(8'd0, 8'd1);
    expect_line(4, 0, 1'b0);
    wait_empty("fs_with_final");
    check("busy_rearmed", busy, 1);
    check("sync_err_total", sync_pulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
